// File: rtl/servo_pkg.sv
// Shared constants and pulse-width arithmetic for the multi-channel servo PWM block.
// Values are carried in a 32-bit word so one function serves every PW_W up to 31.
package servo_pkg;

  localparam int unsigned DEF_FRAME_TICKS = 2000000;
  localparam int unsigned DEF_MIN_PW      = 70000;
  localparam int unsigned DEF_MAX_PW      = 230000;
  localparam int unsigned DEF_STEP        = 4000;

  typedef logic [31:0] pw_word_t;

  // Zero stays zero (channel off); anything else is forced into [min_pw, max_pw].
  function automatic pw_word_t clamp_pw(pw_word_t pw, pw_word_t min_pw, pw_word_t max_pw);
    pw_word_t res;
    res = pw;
    if (pw == '0)
      res = '0;
    else if (pw < min_pw)
      res = min_pw;
    else if (pw > max_pw)
      res = max_pw;
    return res;
  endfunction

  function automatic pw_word_t slew_next(pw_word_t active, pw_word_t target, pw_word_t step);
    pw_word_t    res;
    logic [32:0] diff;
    res  = target;
    diff = (target > active) ? ({1'b0, target} - {1'b0, active})
                             : ({1'b0, active} - {1'b0, target});
    if (target == '0)
      res = '0;
    else if (active == '0)
      res = target;
    else if (step == '0 || diff <= {1'b0, step})
      res = target;
    else if (target > active)
      res = active + step;
    else
      res = active - step;
    return res;
  endfunction

endpackage

// File: rtl/servo_slew.sv
// One servo channel: clamped target register plus a slew-limited active width.
// Target loads on the write edge; active moves only on the frame-end edge; settled lags one cycle.
module servo_slew
  import servo_pkg::*;
#(
  parameter int unsigned PW_W   = 18,
  parameter int unsigned MIN_PW = DEF_MIN_PW,
  parameter int unsigned MAX_PW = DEF_MAX_PW,
  parameter int unsigned STEP   = DEF_STEP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [PW_W-1:0] wr_pw,
  input  logic            frame_end,
  output logic [PW_W-1:0] active,
  output logic            settled
);

  logic [PW_W-1:0] target;

  // The step reads the pre-write target, so a write landing on frame_end waits a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      target  <= '0;
      active  <= '0;
      settled <= 1'b1;
    end else begin
      if (frame_end)
        active <= PW_W'(slew_next(pw_word_t'(active), pw_word_t'(target), pw_word_t'(STEP)));
      if (wr_en)
        target <= PW_W'(clamp_pw(pw_word_t'(wr_pw), pw_word_t'(MIN_PW), pw_word_t'(MAX_PW)));
      settled <= (active == target);
    end
  end

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM: shared frame counter, per-channel slew, registered pwm pins.
// pwm lags the counter by one cycle; cmd_ready is high every cycle once out of reset.
module servo_pwm_multi
  import servo_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned FRAME_TICKS = DEF_FRAME_TICKS,
  parameter int unsigned PW_W        = 18,
  parameter int unsigned MIN_PW      = DEF_MIN_PW,
  parameter int unsigned MAX_PW      = DEF_MAX_PW,
  parameter int unsigned STEP        = DEF_STEP,
  localparam int unsigned CHAN_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [CHAN_W-1:0]   cmd_chan,
  input  logic [PW_W-1:0]     cmd_pw,
  output logic [CHANNELS-1:0] pwm,
  output logic [CHANNELS-1:0] settled,
  output logic                frame_start
);

  localparam int unsigned CNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("servo_pwm_multi: CHANNELS must be 1..16");
  end
  if (MAX_PW >= FRAME_TICKS) begin : g_bad_frame
    $error("servo_pwm_multi: MAX_PW must be below FRAME_TICKS");
  end
  if (MIN_PW > MAX_PW) begin : g_bad_range
    $error("servo_pwm_multi: MIN_PW must not exceed MAX_PW");
  end
  if (PW_W > 31 || 64'(MAX_PW) >= (64'(1) << PW_W)) begin : g_bad_width
    $error("servo_pwm_multi: MAX_PW must fit in PW_W bits");
  end

  logic [CNT_W-1:0]    counter;
  logic                last_tick;
  logic [CHANNELS-1:0] wr_en;
  logic [CHANNELS-1:0] pwm_next;
  logic [PW_W-1:0]     active [CHANNELS];

  assign last_tick = (counter == CNT_W'(FRAME_TICKS - 1));

  always_comb begin
    wr_en    = '0;
    pwm_next = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      // Indices at or beyond CHANNELS match no slot and are dropped here.
      wr_en[i]    = cmd_valid && cmd_ready && (32'(cmd_chan) == 32'(i));
      pwm_next[i] = (32'(counter) < 32'(active[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      counter     <= '0;
      frame_start <= 1'b0;
      cmd_ready   <= 1'b0;
      pwm         <= '0;
    end else begin
      counter     <= last_tick ? '0 : counter + CNT_W'(1);
      frame_start <= last_tick;
      cmd_ready   <= 1'b1;
      pwm         <= pwm_next;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    servo_slew #(
      .PW_W   (PW_W),
      .MIN_PW (MIN_PW),
      .MAX_PW (MAX_PW),
      .STEP   (STEP)
    ) u_slew (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en[i]),
      .wr_pw     (cmd_pw),
      .frame_end (last_tick),
      .active    (active[i]),
      .settled   (settled[i])
    );
  end

endmodule
